// File: rtl/filt_coeff_pkg.sv
// Shared constants and types for the 5x5 filter coefficient loader.
package filt_coeff_pkg;

    localparam int unsigned N_TAPS     = 25;
    localparam int unsigned KERNEL_DIM = 5;
    localparam int unsigned COEFF_W    = 16;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned CENTER_TAP = (N_TAPS - 1) / 2;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StCommit
    } state_e;

    typedef logic signed [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/rise_edge_det.sv
// Single-cycle pulse on each rising edge of a synchronous level input.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic pulse_o
);

    logic in_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_i;
        end
    end

    assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/bram_to_coeff.sv
// Reloads a 5x5 FIR kernel from coefficient BRAM on each vs_i rising edge and commits it atomically.
// Optional macro COEFF_IDENTITY_RESET_EN: reset value of coeff22 becomes 1 (identity kernel).
module bram_to_coeff #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned COEFF_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         filter_coeff_data,
    output logic [ADDR_W-1:0]         filter_coeff_addr,
    input  logic                      vs_i,
    output logic signed [COEFF_W-1:0] coeff00,
    output logic signed [COEFF_W-1:0] coeff01,
    output logic signed [COEFF_W-1:0] coeff02,
    output logic signed [COEFF_W-1:0] coeff03,
    output logic signed [COEFF_W-1:0] coeff04,
    output logic signed [COEFF_W-1:0] coeff10,
    output logic signed [COEFF_W-1:0] coeff11,
    output logic signed [COEFF_W-1:0] coeff12,
    output logic signed [COEFF_W-1:0] coeff13,
    output logic signed [COEFF_W-1:0] coeff14,
    output logic signed [COEFF_W-1:0] coeff20,
    output logic signed [COEFF_W-1:0] coeff21,
    output logic signed [COEFF_W-1:0] coeff22,
    output logic signed [COEFF_W-1:0] coeff23,
    output logic signed [COEFF_W-1:0] coeff24,
    output logic signed [COEFF_W-1:0] coeff30,
    output logic signed [COEFF_W-1:0] coeff31,
    output logic signed [COEFF_W-1:0] coeff32,
    output logic signed [COEFF_W-1:0] coeff33,
    output logic signed [COEFF_W-1:0] coeff34,
    output logic signed [COEFF_W-1:0] coeff40,
    output logic signed [COEFF_W-1:0] coeff41,
    output logic signed [COEFF_W-1:0] coeff42,
    output logic signed [COEFF_W-1:0] coeff43,
    output logic signed [COEFF_W-1:0] coeff44,
    output logic                      en_d
);

    import filt_coeff_pkg::*;

`ifdef COEFF_IDENTITY_RESET_EN
    localparam bit IdentityReset = 1'b1;
`else
    localparam bit IdentityReset = 1'b0;
`endif

    localparam logic [4:0] LastAddr = 5'(N_TAPS - 1);
    localparam logic [4:0] LastCnt  = 5'(N_TAPS);

    state_e                    state_q, state_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      en_q;
    logic                      vs_rise;
    logic                      cap_en;
    logic [4:0]                slot;
    logic signed [COEFF_W-1:0] shadow_q [N_TAPS];
    logic signed [COEFF_W-1:0] coeff_q  [N_TAPS];
    logic                      unused_data;

    rise_edge_det u_vs_edge (
        .clk     (clk),
        .rst     (rst),
        .in_i    (vs_i),
        .pulse_o (vs_rise)
    );

    // BRAM has one cycle of read latency, so the word seen during count c belongs to slot c-1.
    assign cap_en      = (state_q == StRead) && (cnt_q != 5'd0);
    assign slot        = cnt_q - 5'd1;
    assign unused_data = ^filter_coeff_data[DATA_W-1:COEFF_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                addr_d = '0;
                if (vs_rise) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end
            end
            StRead: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q < LastAddr) begin
                    addr_d = ADDR_W'(cnt_q) + ADDR_W'(1);
                end
                if (cnt_q == LastCnt) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
                addr_d  = '0;
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                coeff_q[i] <= (IdentityReset && i == CENTER_TAP) ? COEFF_W'(1) : '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (state_q == StCommit) begin
                en_q <= 1'b1;
                for (int unsigned i = 0; i < N_TAPS; i++) begin
                    coeff_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            if (cap_en && slot == 5'(i)) begin
                shadow_q[i] <= filter_coeff_data[COEFF_W-1:0];
            end
        end
    end

    assign filter_coeff_addr = addr_q;
    assign en_d              = en_q;

    assign coeff00 = coeff_q[0];
    assign coeff01 = coeff_q[1];
    assign coeff02 = coeff_q[2];
    assign coeff03 = coeff_q[3];
    assign coeff04 = coeff_q[4];
    assign coeff10 = coeff_q[5];
    assign coeff11 = coeff_q[6];
    assign coeff12 = coeff_q[7];
    assign coeff13 = coeff_q[8];
    assign coeff14 = coeff_q[9];
    assign coeff20 = coeff_q[10];
    assign coeff21 = coeff_q[11];
    assign coeff22 = coeff_q[12];
    assign coeff23 = coeff_q[13];
    assign coeff24 = coeff_q[14];
    assign coeff30 = coeff_q[15];
    assign coeff31 = coeff_q[16];
    assign coeff32 = coeff_q[17];
    assign coeff33 = coeff_q[18];
    assign coeff34 = coeff_q[19];
    assign coeff40 = coeff_q[20];
    assign coeff41 = coeff_q[21];
    assign coeff42 = coeff_q[22];
    assign coeff43 = coeff_q[23];
    assign coeff44 = coeff_q[24];

endmodule

// File: tb/tb_bram_to_coeff.sv
// Bench for bram_to_coeff: BRAM model, frame-level reference model and directed scenarios.
module tb_bram_to_coeff;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               vs_i = 1'b0;
    logic [31:0]        bram_q = '0;
    logic [5:0]         addr;
    logic               en_d;
    logic signed [15:0] c00, c01, c02, c03, c04, c10, c11, c12, c13, c14;
    logic signed [15:0] c20, c21, c22, c23, c24, c30, c31, c32, c33, c34;
    logic signed [15:0] c40, c41, c42, c43, c44;
    logic [399:0]       dut_vec, exp_vec;

    logic [31:0]        mem [64];
    int                 checks = 0;
    int                 errors = 0;
    int                 sweeps = 0;
    bit                 check_en = 1'b0;
    logic [5:0]         prev_addr = '0;

    // Reference model: cycle offset from the accepted vs_i edge
    bit                 m_busy = 1'b0;
    bit                 m_vs_prev = 1'b0;
    int                 m_k = 0;
    bit                 m_en = 1'b0;
    logic signed [15:0] m_coeff [25];

`ifdef COEFF_IDENTITY_RESET_EN
    localparam logic signed [15:0] RstC22 = 16'sd1;
`else
    localparam logic signed [15:0] RstC22 = 16'sd0;
`endif

    bram_to_coeff dut (
        .clk (clk), .rst (rst), .filter_coeff_data (bram_q), .filter_coeff_addr (addr),
        .vs_i (vs_i),
        .coeff00 (c00), .coeff01 (c01), .coeff02 (c02), .coeff03 (c03), .coeff04 (c04),
        .coeff10 (c10), .coeff11 (c11), .coeff12 (c12), .coeff13 (c13), .coeff14 (c14),
        .coeff20 (c20), .coeff21 (c21), .coeff22 (c22), .coeff23 (c23), .coeff24 (c24),
        .coeff30 (c30), .coeff31 (c31), .coeff32 (c32), .coeff33 (c33), .coeff34 (c34),
        .coeff40 (c40), .coeff41 (c41), .coeff42 (c42), .coeff43 (c43), .coeff44 (c44),
        .en_d (en_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bram_q <= mem[addr];

    assign dut_vec = {c44, c43, c42, c41, c40, c34, c33, c32, c31, c30, c24, c23, c22, c21, c20,
                      c14, c13, c12, c11, c10, c04, c03, c02, c01, c00};

    always_comb begin
        exp_vec = '0;
        for (int i = 0; i < 25; i++) exp_vec[i*16 +: 16] = m_coeff[i];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy    = 1'b0;
            m_vs_prev = 1'b0;
            m_k       = 0;
            m_en      = 1'b0;
            for (int i = 0; i < 25; i++) m_coeff[i] = (i == 12) ? RstC22 : 16'sd0;
        end else begin
            if (m_busy) begin
                m_k++;
                if (m_k == 27) begin
                    for (int i = 0; i < 25; i++) m_coeff[i] = mem[i][15:0];
                    m_en   = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (vs_i && !m_vs_prev) begin
                m_busy = 1'b1;
                m_k    = 0;
            end
            m_vs_prev = vs_i;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            automatic int exp_addr = !m_busy ? 0 : (m_k > 24 ? 24 : m_k);
            checks++;
            if (addr !== 6'(exp_addr)) begin
                errors++;
                $display("FAIL addr @%0t: got %0d expected %0d", $time, addr, exp_addr);
            end
            checks++;
            if (en_d !== m_en) begin
                errors++;
                $display("FAIL en_d @%0t: got %0b expected %0b", $time, en_d, m_en);
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL coeffs @%0t: got %h expected %h", $time, dut_vec, exp_vec);
            end
            if (addr == 6'd1 && prev_addr == 6'd0) sweeps++;
            prev_addr = addr;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_vs(input int hi);
        vs_i = 1'b1;
        tick(hi);
        vs_i = 1'b0;
    endtask

    task automatic fill_mem(input int base);
        for (int i = 0; i < 64; i++) mem[i] = 32'(base + i);
    endtask

    initial begin
        int sw0;
        fill_mem(0);
        tick(2);
        check_en = 1'b1;
        tick(1);
        chk("reset en_d", int'(en_d), 0);
        chk("reset addr", int'(addr), 0);
        chk("reset coeff22", int'(c22), int'(RstC22));
        rst = 1'b1;
        tick(2);

        // Basic load, vs_i high 2 cycles; now at E0+1
        pulse_vs(2);
        tick(25);
        chk("pre-commit coeff44", int'(c44), 0);
        chk("pre-commit en_d", int'(en_d), 0);
        tick(1);
        chk("load coeff00", int'(c00), 0);
        chk("load coeff24", int'(c24), 14);
        chk("load coeff44", int'(c44), 24);
        chk("load en_d", int'(en_d), 1);
        chk("load sweeps", sweeps, 1);

        // vs_i held 10 cycles gives a single sweep
        tick(3);
        sw0 = sweeps;
        pulse_vs(10);
        tick(30);
        chk("held vs sweeps", sweeps - sw0, 1);
        chk("held vs addr idle", int'(addr), 0);

        // Sign and truncation
        mem[12] = 32'hABCD_8000;
        mem[0]  = 32'h0000_7FFF;
        pulse_vs(1);
        tick(30);
        chk("sign coeff22", int'(c22), -32768);
        chk("sign coeff00", int'(c00), 32767);

        // Reload atomicity
        fill_mem(0);
        pulse_vs(1);
        tick(30);
        fill_mem(100);
        tick(30);
        pulse_vs(2);
        tick(25);
        chk("reload hold coeff43", int'(c43), 23);
        chk("reload hold en_d", int'(en_d), 1);
        tick(1);
        chk("reload coeff43", int'(c43), 123);
        chk("reload coeff00", int'(c00), 100);

        // Second edge during READ is ignored; now at E0 after the first pulse
        fill_mem(200);
        tick(3);
        sw0 = sweeps;
        pulse_vs(1);
        tick(9);
        pulse_vs(1);
        tick(16);
        chk("ignored edge pre-commit", int'(c00), 100);
        tick(1);
        chk("ignored edge commit", int'(c00), 200);
        tick(30);
        chk("ignored edge sweeps", sweeps - sw0, 1);

        // Reset mid-load at E0+15
        fill_mem(0);
        pulse_vs(1);
        tick(15);
        rst = 1'b0;
        #1;
        chk("abort en_d", int'(en_d), 0);
        chk("abort addr", int'(addr), 0);
        chk("abort coeff22", int'(c22), int'(RstC22));
        chk("abort coeff44", int'(c44), 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        pulse_vs(2);
        tick(30);
        chk("post-abort coeff44", int'(c44), 24);
        chk("post-abort coeff22", int'(c22), 12);
        chk("post-abort en_d", int'(en_d), 1);

        tick(2);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
